// File: rtl/clk_divider.sv
// Integer clock divider: produces new_clk (period DIV_RATIO clk cycles) and a one-cycle
// new_clk_tick strobe in the clk domain. Optional macro: CLK_DIVIDER_ODD_DUTY_EN (50 % duty for odd ratios).
module clk_divider #(
  parameter int DIV_RATIO = 4,
  parameter int CNT_W     = $clog2(DIV_RATIO)
) (
  input  logic clk,
  input  logic rst_n,
  output logic new_clk,
  output logic new_clk_tick
);

  if (DIV_RATIO < 2) begin : g_bad_ratio
    $error("clk_divider: DIV_RATIO must be >= 2");
  end

  localparam int HIGH = DIV_RATIO / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_FALL = CNT_W'(HIGH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    rise_d = rise_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      rise_d = 1'b1;
      tick_d = 1'b1;
    end else if (cnt_q == CNT_FALL) begin
      rise_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rise_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      tick_q <= tick_d;
    end
  end

  assign new_clk_tick = tick_q;

`ifdef CLK_DIVIDER_ODD_DUTY_EN
  if ((DIV_RATIO % 2) == 1) begin : g_odd_duty
    // Half-cycle stretch of the high phase: rise edge unchanged, fall moves half a clk later.
    logic fall_q;
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) fall_q <= 1'b0;
      else        fall_q <= rise_q;
    end
    assign new_clk = rise_q | fall_q;
  end else begin : g_even_duty
    assign new_clk = rise_q;
  end
`else
  assign new_clk = rise_q;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Scoreboard bench for clk_divider at ratios 4, 5 and 2, sharing one clock and reset.
module tb_clk_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic c4, t4, c5, t5, c2, t2;

  always #5 clk = ~clk;

  clk_divider #(.DIV_RATIO(4)) u_r4 (.clk(clk), .rst_n(rst_n), .new_clk(c4), .new_clk_tick(t4));
  clk_divider #(.DIV_RATIO(5)) u_r5 (.clk(clk), .rst_n(rst_n), .new_clk(c5), .new_clk_tick(t5));
  clk_divider #(.DIV_RATIO(2)) u_r2 (.clk(clk), .rst_n(rst_n), .new_clk(c2), .new_clk_tick(t2));

  // Hand-computed steady-state patterns, bit j = value just after release edge k with j = (k-1) % R.
  logic [3:0] r4c = 4'b1001;
  logic [3:0] r4t = 4'b1000;
`ifdef CLK_DIVIDER_ODD_DUTY_EN
  logic [4:0] r5c = 5'b10011;
`else
  logic [4:0] r5c = 5'b10001;
`endif
  logic [4:0] r5t = 5'b10000;
  logic [1:0] r2c = 2'b10;
  logic [1:0] r2t = 2'b10;

  logic [5:0] sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int rise_cnt = 0;
  logic prev_c4 = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // k = 0 means "in reset"; before the first rise at edge R everything is low.
  function automatic logic [5:0] exp_at(input int k);
    logic [5:0] e;
    e = '0;
    if (k >= 4) begin e[5] = r4c[(k-1)%4]; e[4] = r4t[(k-1)%4]; end
    if (k >= 5) begin e[3] = r5c[(k-1)%5]; e[2] = r5t[(k-1)%5]; end
    if (k >= 2) begin e[1] = r2c[(k-1)%2]; e[0] = r2t[(k-1)%2]; end
    return e;
  endfunction

  always @(posedge clk) begin
    logic [5:0] e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("r4_new_clk",  c4, e[5]);
      check("r4_tick",     t4, e[4]);
      check("r5_new_clk",  c5, e[3]);
      check("r5_tick",     t5, e[2]);
      check("r2_new_clk",  c2, e[1]);
      check("r2_tick",     t2, e[0]);
      if (c4 && !prev_c4) rise_cnt++;
      prev_c4 = c4;
    end
  end

  initial begin
    // Reset window: outputs must be low before any counting starts.
    #1;
    check("reset_r4_new_clk", c4, 1'b0);
    check("reset_r4_tick",    t4, 1'b0);
    check("reset_r5_new_clk", c5, 1'b0);
    check("reset_r2_new_clk", c2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(exp_at(0));
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      sb_q.push_back(exp_at(k));
      @(posedge clk);
    end

    // Edge 40 is a ratio-4 rise: new_clk and tick are high here; reset must clear them with no edge.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_r4_new_clk", c4, 1'b0);
    check("async_r4_tick",    t4, 1'b0);
    check("async_r5_new_clk", c5, 1'b0);
    check("async_r2_new_clk", c2, 1'b0);
    check("async_r2_tick",    t2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(exp_at(0));
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    rise_cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      sb_q.push_back(exp_at(k));
      @(posedge clk);
    end
    #3;
    // Rises at edges 4, 8, ..., 200.
    n_cmp++;
    if (rise_cnt != 50) begin
      n_bad++;
      $display("FAIL r4_rise_count: got %0d expected %0d", rise_cnt, 50);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
